// File: rtl/dmem_responder_pkg.sv
// Shared types and defaults for the data-memory responder and its RAM.
package dmem_responder_pkg;

    localparam int dmem_depth_default = 1024;
    localparam int dmem_wait_default  = 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_type;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        fence;
        logic        spec;
        logic [3:0]  wait_cnt;
    } dmem_req_reg_type;

endpackage

// File: rtl/dmem_ram.sv
// DEPTH x 32 word RAM with per-byte write enables and a registered read.
// A same-cycle write to the read address is forwarded byte-wise into the read data.
module dmem_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic [3:0]    wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [31:0]   wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [31:0]   rd_data_o
);

    // NOTE: the storage array has no reset; clearing it would turn the RAM into flops.
    logic [31:0] mem_q [DEPTH];
    logic [31:0] rd_data_q;

    // NOTE: clocked state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_en_i[b]) begin
                mem_q[wr_addr_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
            end
            rd_data_q[b*8 +: 8] <= (wr_en_i[b] && (wr_addr_i == rd_addr_i))
                                   ? wr_data_i[b*8 +: 8]
                                   : mem_q[rd_addr_i][b*8 +: 8];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: request latch, IDLE/WAIT/RESP FSM, range check and response muxing.
// Optional feature: define DMEM_RANGE_CHECK_EN to fault accesses outside the RAM window.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH       = dmem_depth_default,
    parameter int          WAIT_CYCLES = dmem_wait_default,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_fence,
    input  logic        mem_spec,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_error
);

    localparam int             AW          = $clog2(DEPTH);
    localparam logic [3:0]     CNT_LAST    = 4'(WAIT_CYCLES - 1);
    localparam dmem_state_type START_STATE = (WAIT_CYCLES > 0) ? WAIT : RESP;

    dmem_state_type   state_q, state_d;
    dmem_req_reg_type req_q, req_d;

    logic [31:0]   in_off, req_off, ram_rdata;
    logic [AW-1:0] rd_idx, wr_idx;
    logic [3:0]    wr_en;
    logic          range_ok, resp_active, is_fence, is_store, is_load;
    logic          unused_bits;

    assign in_off  = mem_addr - BASE_ADDR;
    assign req_off = req_q.addr - BASE_ADDR;
    // The read must launch one cycle before RESP: from the latch in WAIT, else straight off the bus.
    assign rd_idx  = (state_q == WAIT) ? req_off[AW+1:2] : in_off[AW+1:2];
    assign wr_idx  = req_off[AW+1:2];

`ifdef DMEM_RANGE_CHECK_EN
    assign range_ok = (req_off >> (AW + 2)) == 32'd0;
`else
    assign range_ok = 1'b1;
`endif

    assign resp_active = (state_q == RESP) && reset;
    assign is_fence    = req_q.fence;
    assign is_store    = !req_q.fence && (req_q.wstrb != 4'd0);
    assign is_load     = !req_q.fence && (req_q.wstrb == 4'd0);
    assign wr_en       = (resp_active && is_store && range_ok) ? req_q.wstrb : 4'd0;

    assign mem_ready = resp_active;
    assign mem_rdata = (resp_active && is_load && range_ok) ? ram_rdata : 32'd0;
`ifdef DMEM_RANGE_CHECK_EN
    assign mem_error = resp_active && !is_fence && !range_ok && !req_q.spec;
`else
    assign mem_error = 1'b0;
`endif

    assign unused_bits = ^{mem_instr, in_off, req_off, req_q.spec, is_fence};

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
        state_d = state_q;
        req_d   = req_q;
        unique case (state_q)
            IDLE, RESP: begin
                state_d = IDLE;
                if (mem_valid) begin
                    req_d = '{addr: mem_addr, wdata: mem_wdata, wstrb: mem_wstrb,
                              fence: mem_fence, spec: mem_spec, wait_cnt: 4'd0};
                    state_d = START_STATE;
                end
            end
            WAIT: begin
                if (req_q.wait_cnt == CNT_LAST) begin
                    state_d = RESP;
                end else begin
                    req_d.wait_cnt = req_q.wait_cnt + 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= IDLE;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    dmem_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clock     (clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_idx),
        .wr_data_i (req_q.wdata),
        .rd_addr_i (rd_idx),
        .rd_data_o (ram_rdata)
    );

    // The requester never issues while a request is still waiting.
    assert property (@(posedge clock) disable iff (!reset) !(state_q == WAIT && mem_valid));

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (0, 3 and 4 wait cycles) against a word-array reference model.
module tb_dmem_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;
`ifdef DMEM_RANGE_CHECK_EN
    localparam bit RANGED = 1'b1;
`else
    localparam bit RANGED = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        valid [3];
    logic        fence [3];
    logic        spec  [3];
    logic        instr [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic        ready [3];
    logic [31:0] rdata [3];
    logic        error [3];

    logic [31:0] ref_mem [3][DEPTH];
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE)) u_w0 (
        .clock(clock), .reset(reset), .mem_valid(valid[0]), .mem_fence(fence[0]),
        .mem_spec(spec[0]), .mem_instr(instr[0]), .mem_addr(addr[0]), .mem_wdata(wdata[0]),
        .mem_wstrb(wstrb[0]), .mem_ready(ready[0]), .mem_rdata(rdata[0]), .mem_error(error[0]));

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3), .BASE_ADDR(BASE)) u_w3 (
        .clock(clock), .reset(reset), .mem_valid(valid[1]), .mem_fence(fence[1]),
        .mem_spec(spec[1]), .mem_instr(instr[1]), .mem_addr(addr[1]), .mem_wdata(wdata[1]),
        .mem_wstrb(wstrb[1]), .mem_ready(ready[1]), .mem_rdata(rdata[1]), .mem_error(error[1]));

    dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(4), .BASE_ADDR(BASE)) u_w4 (
        .clock(clock), .reset(reset), .mem_valid(valid[2]), .mem_fence(fence[2]),
        .mem_spec(spec[2]), .mem_instr(instr[2]), .mem_addr(addr[2]), .mem_wdata(wdata[2]),
        .mem_wstrb(wstrb[2]), .mem_ready(ready[2]), .mem_rdata(rdata[2]), .mem_error(error[2]));

    function automatic int wait_of(input int k);
        return (k == 0) ? 0 : (k == 1) ? 3 : 4;
    endfunction

    // Reference: what the requester should see for one request, and its effect on the RAM.
    task automatic model(input int k, input bit f, input bit s, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] st,
                         output logic [31:0] exp_rdata, output logic exp_err);
        logic [31:0] off;
        int          idx;
        bit          in_range;
        off       = a - BASE;
        idx       = int'((off / 4) % DEPTH);
        in_range  = off < DEPTH * 4;
        exp_rdata = 32'd0;
        exp_err   = 1'b0;
        if (f) begin
            exp_rdata = 32'd0;
        end else if (RANGED && !in_range) begin
            exp_err = !s;
        end else if (st != 4'd0) begin
            for (int b = 0; b < 4; b++)
                if (st[b]) ref_mem[k][idx][b*8 +: 8] = d[b*8 +: 8];
        end else begin
            exp_rdata = ref_mem[k][idx];
        end
    endtask

    task automatic idle_in(input int k);
        valid[k] = 1'b0;
        fence[k] = 1'($urandom);
        spec[k]  = 1'($urandom);
        instr[k] = 1'($urandom);
        addr[k]  = $urandom;
        wdata[k] = $urandom;
        wstrb[k] = 4'($urandom);
    endtask

    task automatic drive(input int k, input bit f, input bit s, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] st);
        valid[k] = 1'b1;
        fence[k] = f;
        spec[k]  = s;
        instr[k] = 1'($urandom);
        addr[k]  = a;
        wdata[k] = d;
        wstrb[k] = st;
    endtask

    // Called at the negedge of the issue cycle; returns at the negedge of the response cycle.
    task automatic expect_resp(input int k, input bit f, input bit s, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] st, input string name,
                               output logic [31:0] got_rdata, output logic got_err);
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          w;
        w = wait_of(k);
        model(k, f, s, a, d, st, exp_rdata, exp_err);
        got_rdata = 32'hx;
        got_err   = 1'bx;
        for (int c = 1; c <= w + 1; c++) begin
            @(negedge clock);
            if (c == 1) idle_in(k);
            checks++;
            if (c <= w) begin
                if (ready[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL %s early_ready cycle %0d: got %b want 0", name, c, ready[k]);
                end
            end else begin
                if (ready[k] !== 1'b1) begin
                    errors++;
                    $display("FAIL %s ready cycle %0d: got %b want 1", name, c, ready[k]);
                end
                checks++;
                if (rdata[k] !== exp_rdata) begin
                    errors++;
                    $display("FAIL %s rdata: got %h want %h", name, rdata[k], exp_rdata);
                end
                checks++;
                if (error[k] !== exp_err) begin
                    errors++;
                    $display("FAIL %s error: got %b want %b", name, error[k], exp_err);
                end
                got_rdata = rdata[k];
                got_err   = error[k];
            end
        end
    endtask

    task automatic request(input int k, input bit f, input bit s, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] st, input string name,
                           output logic [31:0] got_rdata, output logic got_err);
        drive(k, f, s, a, d, st);
        expect_resp(k, f, s, a, d, st, name, got_rdata, got_err);
    endtask

    task automatic expect_word(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic gap();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) idle_in(k);
        repeat (3) @(negedge clock);
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (ready[k] !== 1'b0 || rdata[k] !== 32'd0 || error[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs inst %0d: got ready=%b rdata=%h error=%b want 0/0/0",
                         k, ready[k], rdata[k], error[k]);
            end
        end
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_load_after_store();
        logic [31:0] r;
        logic        e;
        request(0, 0, 0, 32'h10, 32'hDEAD_BEEF, 4'hF, "las_store", r, e);
        gap();
        request(0, 0, 0, 32'h10, 32'h0, 4'h0, "las_load", r, e);
        expect_word("las_literal", r, 32'hDEAD_BEEF);
    endtask

    task automatic test_byte_strobes(input int k);
        logic [31:0] r;
        logic        e;
        request(k, 0, 0, 32'h20, 32'h1122_3344, 4'hF, "bs_full", r, e);
        gap();
        request(k, 0, 0, 32'h20, 32'h0000_AA00, 4'h2, "bs_lane1", r, e);
        gap();
        request(k, 0, 0, 32'h20, 32'h0, 4'h0, "bs_load", r, e);
        expect_word("bs_literal", r, 32'h1122_AA44);
    endtask

    task automatic test_wait_states();
        logic [31:0] r;
        logic        e;
        request(1, 0, 0, 32'h20, 32'h0, 4'h0, "ws_single", r, e);
        @(negedge clock);
        checks++;
        if (ready[1] !== 1'b0) begin
            errors++;
            $display("FAIL ws_single_one_pulse: got %b want 0", ready[1]);
        end
        request(1, 0, 0, 32'h20, 32'h0, 4'h0, "ws_b2b_first", r, e);
        request(1, 0, 0, 32'h20, 32'h0, 4'h0, "ws_b2b_second", r, e);
        expect_word("ws_b2b_literal", r, 32'h1122_AA44);
    endtask

    task automatic test_fence();
        logic [31:0] r;
        logic        e;
        request(0, 0, 0, 32'h30, 32'hCAFE_F00D, 4'hF, "fence_prep", r, e);
        gap();
        request(0, 1, 0, 32'h30, 32'h1234_5678, 4'hF, "fence_req", r, e);
        gap();
        request(0, 0, 0, 32'h30, 32'h0, 4'h0, "fence_check", r, e);
        expect_word("fence_literal", r, 32'hCAFE_F00D);
    endtask

    task automatic test_range();
        logic [31:0] r;
        logic        e;
        request(0, 0, 0, 32'h0, 32'hA5A5_A5A5, 4'hF, "rng_prep", r, e);
        gap();
        request(0, 0, 0, 32'h1000, 32'h0, 4'h0, "rng_load_nospec", r, e);
        checks++;
        if (e !== RANGED) begin
            errors++;
            $display("FAIL rng_error_literal: got %b want %b", e, RANGED);
        end
        gap();
        request(0, 0, 1, 32'h1000, 32'h0, 4'h0, "rng_load_spec", r, e);
        gap();
        request(0, 0, 0, 32'h1000, 32'h5A5A_5A5A, 4'hF, "rng_store", r, e);
        gap();
        request(0, 0, 0, 32'h0, 32'h0, 4'h0, "rng_word0", r, e);
        expect_word("rng_word0_literal", r, RANGED ? 32'hA5A5_A5A5 : 32'h5A5A_5A5A);
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] r;
        logic        e;
        request(2, 0, 0, 32'h40, 32'h0BAD_F00D, 4'hF, "rmo_prep", r, e);
        gap();
        drive(2, 0, 0, 32'h40, 32'hFFFF_FFFF, 4'hF);
        @(negedge clock);
        idle_in(2);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (ready[2] !== 1'b0) begin
                errors++;
                $display("FAIL rmo_no_ready cycle %0d: got %b want 0", c, ready[2]);
            end
            @(negedge clock);
        end
        request(2, 0, 0, 32'h40, 32'h0, 4'h0, "rmo_load", r, e);
        expect_word("rmo_literal", r, 32'h0BAD_F00D);
    endtask

    task automatic test_random(input int k, input int n_ops);
        int          pool [8];
        logic [31:0] r, a, d;
        logic [3:0]  st;
        logic        e;
        bit          f;
        int          op;
        for (int i = 0; i < 8; i++) begin
            pool[i] = $urandom_range(0, DEPTH - 1);
            request(k, 0, 0, BASE + 32'(pool[i] * 4), $urandom, 4'hF, "rnd_fill", r, e);
        end
        for (int i = 0; i < n_ops; i++) begin
            a  = BASE + 32'(pool[$urandom_range(0, 7)] * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 4) == 0) a = a + 32'h1000 * 32'($urandom_range(1, 3));
            d  = $urandom;
            op = $urandom_range(0, 9);
            f  = (op == 0);
            st = (op == 0) ? 4'($urandom) : (op < 5) ? 4'($urandom_range(1, 15)) : 4'h0;
            request(k, f, 1'($urandom), a, d, st, "rnd_op", r, e);
            if ($urandom_range(0, 1) == 0) gap();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_after_store();
        gap();
        test_byte_strobes(0);
        gap();
        test_byte_strobes(1);
        gap();
        test_wait_states();
        gap();
        test_fence();
        gap();
        test_range();
        gap();
        test_reset_mid_op();
        gap();
        test_random(0, 40);
        gap();
        test_random(1, 30);
        gap();
        test_random(2, 20);
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
